ysyx_22040895_ifu_ctrl: RTL

- Instruction-fetch sequencer between the PC state and the instruction memory port.
- Owns the architectural fetch PC and issues one imem request at a time over a valid/ready handshake.
- Presents each fetched instruction to decode with valid/ready.
- Applies trap and branch redirects, and discards stale (wrong-path) responses.

---
 rtl/ysyx_22040895_ifu_ctrl_pkg.sv | 22 ++
 rtl/ysyx_22040895_ifu_ctrl_redir.sv | 54 +++++
 rtl/ysyx_22040895_ifu_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_ifu_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM encoding,
// default widths and the post-reset fetch address.
package ysyx_22040895_ifu_ctrl_pkg;

  localparam int          INST_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 64;
  localparam int          InstAddrBus  = ADDR_W_DEF;
  localparam int          InstBus      = INST_W_DEF;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  function automatic logic pc_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040895_ifu_ctrl_redir.sv
// Redirect source select (trap over branch) and the pending-redirect latch
// that holds a target until the fetch FSM is able to act on it.
module ysyx_22040895_redir_latch
  import ysyx_22040895_ifu_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              redir_valid_i,
  input  logic [ADDR_W-1:0] redir_pc_i,
  input  logic              consume_i,
  output logic              rd_valid_o,
  output logic              pend_v_o,
  output logic              tgt_valid_o,
  output logic [ADDR_W-1:0] tgt_pc_o
);

  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] rd_pc;

  assign rd_valid_o = trap_valid_i | redir_valid_i;
  assign rd_pc      = trap_valid_i ? trap_pc_i : redir_pc_i;

  // A redirect seen this cycle is always newer than anything already latched.
  assign tgt_valid_o = rd_valid_o | pend_v_q;
  assign tgt_pc_o    = rd_valid_o ? rd_pc : pend_pc_q;
  assign pend_v_o    = pend_v_q;

  always_comb begin
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    if (consume_i) begin
      pend_v_d = 1'b0;
    end else if (rd_valid_o) begin
      pend_v_d  = 1'b1;
      pend_pc_d = rd_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

endmodule

// File: rtl/ysyx_22040895_ifu_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time,
// hands instructions to decode and squashes wrong-path responses.
module ysyx_22040895_ifu_ctrl
  import ysyx_22040895_ifu_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              redir_valid_i,
  input  logic [ADDR_W-1:0] redir_pc_i,
  output logic              imem_req_valid_o,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_misalign_o,
  input  logic              inst_ready_i
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              mis_q, mis_d;

  logic              consume;
  logic              rd_v, pend_v, tgt_v;
  logic [ADDR_W-1:0] tgt_pc;
  logic              pc_mis;

  ysyx_22040895_redir_latch #(.ADDR_W(ADDR_W)) u_redir (
    .clk          (clk),
    .rst          (rst),
    .trap_valid_i (trap_valid_i),
    .trap_pc_i    (trap_pc_i),
    .redir_valid_i(redir_valid_i),
    .redir_pc_i   (redir_pc_i),
    .consume_i    (consume),
    .rd_valid_o   (rd_v),
    .pend_v_o     (pend_v),
    .tgt_valid_o  (tgt_v),
    .tgt_pc_o     (tgt_pc)
  );

  assign pc_mis = pc_misaligned(pc_q[1:0]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    mis_d     = mis_q;
    consume   = 1'b0;
    case (state_q)
      S_IDLE: begin
        consume = 1'b1;
        if (tgt_v) pc_d = tgt_pc;
        state_d = S_REQ;
      end
      S_REQ: begin
        // Misaligned PCs never reach imem; decode gets a flagged bubble.
        if (pc_mis) begin
          inst_d    = '0;
          inst_pc_d = pc_q;
          mis_d     = 1'b1;
          state_d   = S_HOLD;
        end else if (imem_req_ready_i) begin
          drop_d  = pend_v | rd_v;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_v) drop_d = 1'b1;
        if (imem_rsp_valid_i) begin
          if (drop_q || rd_v) begin
            pc_d    = tgt_pc;
            consume = 1'b1;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data_i;
            inst_pc_d = pc_q;
            mis_d     = 1'b0;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Redirect beats the decode handshake even when both land together.
        if (tgt_v) begin
          pc_d    = tgt_pc;
          consume = 1'b1;
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      mis_q     <= mis_d;
    end
  end

  assign imem_req_valid_o = (state_q == S_REQ) && !pc_mis;
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = (state_q == S_HOLD);
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign inst_misalign_o  = mis_q;

endmodule
